// File: rtl/fp32_normalize_shifter.sv
// -----------------------------------------------------------------------------
// fp32_normalize_shifter
// Two-stage normalization shifter for the fp32 adder datapath. It takes the
// unnormalized significand plus the leading-1 position from the priority
// encoder and returns a significand with the MSB at bit 23 and the adjusted
// biased exponent. Results that would need an exponent at or below zero are
// handled at the underflow floor.
//
// Build option:
//   FP32_NORM_DENORM_EN  defined   -> gradual underflow (subnormal output)
//                        undefined -> flush-to-zero at the floor
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid / in_ready           input handshake
//   in_significand[23:0]          unnormalized magnitude (bit 23 = hidden bit)
//   in_exponent[7:0]              biased exponent before normalization
//   in_sign                       sign, passed through
//   in_shift[4:0]                 leading-1 position (0 = bit 23 set)
//   out_valid / out_ready         output handshake
//   out_significand[23:0]         normalized / subnormal / zero significand
//   out_exponent[7:0]             adjusted biased exponent (0 if sub/zero)
//   out_sign                      registered sign
//   out_zero                      result is exactly zero
//   out_underflow                 requested shift hit the exponent floor
// -----------------------------------------------------------------------------
module fp32_normalize_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_significand,
   input  logic [7:0]  in_exponent,
   input  logic        in_sign,
   input  logic [4:0]  in_shift,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] out_significand,
   output logic [7:0]  out_exponent,
   output logic        out_sign,
   output logic        out_zero,
   output logic        out_underflow
);

   // S1: raw significand plus decoded shift amount, final exponent and flags
   logic        s1_vld_q;
   logic [23:0] s1_sig_q;
   logic [4:0]  s1_shamt_q, s1_shamt_d;
   logic [7:0]  s1_exp_q, s1_exp_d;
   logic        s1_sign_q;
   logic        s1_zero_q, s1_zero_d;
   logic        s1_uf_q, s1_uf_d;

   // S2: shifted result, drives the outputs directly
   logic        s2_vld_q;
   logic [23:0] s2_sig_q, s2_sig_d;
   logic [7:0]  s2_exp_q;
   logic        s2_sign_q;
   logic        s2_zero_q;
   logic        s2_uf_q;

   logic        s2_can_accept;
   logic        sig_is_zero;
   logic        at_floor;

   assign s2_can_accept = !s2_vld_q || out_ready;
   assign in_ready      = !s1_vld_q || s2_can_accept;

   assign sig_is_zero = (in_significand == 24'd0);
   assign at_floor    = (in_exponent <= {3'b000, in_shift});

   // Decode effective shift, exponent and flags ahead of the S1 register so
   // S2 only has to do the barrel shift.
   always_comb begin
      s1_shamt_d = in_shift;
      s1_exp_d   = in_exponent - {3'b000, in_shift};
      s1_zero_d  = 1'b0;
      s1_uf_d    = 1'b0;
      if (sig_is_zero) begin
         s1_shamt_d = 5'd0;
         s1_exp_d   = 8'd0;
         s1_zero_d  = 1'b1;
      end else if (at_floor) begin
         s1_uf_d  = 1'b1;
         s1_exp_d = 8'd0;
`ifdef FP32_NORM_DENORM_EN
         // At the floor in_exponent <= in_shift <= 31, so the low 5 bits hold
         // the whole exponent and exponent-1 cannot wrap except at 0.
         if (in_exponent == 8'd0) s1_shamt_d = 5'd0;
         else                     s1_shamt_d = in_exponent[4:0] - 5'd1;
`else
         s1_shamt_d = 5'd0;
         s1_zero_d  = 1'b1;
`endif
      end
   end

   // Shift never exceeds the leading-1 position, so nothing set falls off the top.
   always_comb begin
      s2_sig_d = s1_zero_q ? 24'd0 : (s1_sig_q << s1_shamt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_sig_q   <= 24'd0;
         s1_shamt_q <= 5'd0;
         s1_exp_q   <= 8'd0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_uf_q    <= 1'b0;
      end else begin
         if (in_ready) s1_vld_q <= in_valid;
         if (in_valid && in_ready) begin
            s1_sig_q   <= in_significand;
            s1_shamt_q <= s1_shamt_d;
            s1_exp_q   <= s1_exp_d;
            s1_sign_q  <= in_sign;
            s1_zero_q  <= s1_zero_d;
            s1_uf_q    <= s1_uf_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q  <= 1'b0;
         s2_sig_q  <= 24'd0;
         s2_exp_q  <= 8'd0;
         s2_sign_q <= 1'b0;
         s2_zero_q <= 1'b0;
         s2_uf_q   <= 1'b0;
      end else begin
         if (s2_can_accept) s2_vld_q <= s1_vld_q;
         if (s1_vld_q && s2_can_accept) begin
            s2_sig_q  <= s2_sig_d;
            s2_exp_q  <= s1_exp_q;
            s2_sign_q <= s1_sign_q;
            s2_zero_q <= s1_zero_q;
            s2_uf_q   <= s1_uf_q;
         end
      end
   end

   assign out_valid       = s2_vld_q;
   assign out_significand = s2_sig_q;
   assign out_exponent    = s2_exp_q;
   assign out_sign        = s2_sign_q;
   assign out_zero        = s2_zero_q;
   assign out_underflow   = s2_uf_q;

endmodule

// File: tb/tb_fp32_normalize_shifter.sv
module tb_fp32_normalize_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_significand;
   logic [7:0]  in_exponent;
   logic        in_sign;
   logic [4:0]  in_shift;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_significand;
   logic [7:0]  out_exponent;
   logic        out_sign;
   logic        out_zero;
   logic        out_underflow;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   fp32_normalize_shifter dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_significand(in_significand), .in_exponent(in_exponent),
      .in_sign(in_sign), .in_shift(in_shift),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_significand(out_significand), .out_exponent(out_exponent),
      .out_sign(out_sign), .out_zero(out_zero), .out_underflow(out_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [23:0] s, input logic [7:0] e, input logic sg, input logic [4:0] sh);
      in_valid = 1'b1; in_significand = s; in_exponent = e; in_sign = sg; in_shift = sh;
   endtask

   task automatic chk_out(input string tag, input logic [23:0] s, input logic [7:0] e,
                          input logic sg, input logic z, input logic uf);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".sig"},   {8'd0, out_significand}, {8'd0, s});
      chk({tag, ".exp"},   {24'd0, out_exponent}, {24'd0, e});
      chk({tag, ".sign"},  {31'd0, out_sign}, {31'd0, sg});
      chk({tag, ".zero"},  {31'd0, out_zero}, {31'd0, z});
      chk({tag, ".uf"},    {31'd0, out_underflow}, {31'd0, uf});
   endtask

   // One beat through an idle pipe with out_ready high: accepted on the
   // first edge, visible after the second.
   task automatic single(input string tag, input logic [23:0] s, input logic [7:0] e,
                         input logic sg, input logic [4:0] sh,
                         input logic [23:0] es, input logic [7:0] ee,
                         input logic ez, input logic euf);
      @(negedge clk);
      put(s, e, sg, sh);
      chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".lat1"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk_out(tag, es, ee, sg, ez, euf);
      @(negedge clk);
      chk({tag, ".drain"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_significand = '0; in_exponent = '0; in_sign = 1'b0; in_shift = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst.sig",       {8'd0, out_significand}, 32'd0);
      chk("rst.exp",       {24'd0, out_exponent}, 32'd0);
      chk("rst.flags",     {29'd0, out_sign, out_zero, out_underflow}, 32'd0);

      single("normal", 24'h00F000, 8'd100, 1'b0, 5'd8,  24'hF00000, 8'd92, 1'b0, 1'b0);
      single("zero",   24'h000000, 8'd77,  1'b1, 5'd5,  24'h000000, 8'd0,  1'b1, 1'b0);
      single("sh0",    24'h800001, 8'd1,   1'b0, 5'd0,  24'h800001, 8'd1,  1'b0, 1'b0);
      single("sh23",   24'h000001, 8'd200, 1'b1, 5'd23, 24'h800000, 8'd177, 1'b0, 1'b0);
`ifdef FP32_NORM_DENORM_EN
      single("floor",    24'h000100, 8'd5, 1'b0, 5'd15, 24'h001000, 8'd0, 1'b0, 1'b1);
      single("floor_eq", 24'h008000, 8'd8, 1'b1, 5'd8,  24'h400000, 8'd0, 1'b0, 1'b1);
      single("floor_e0", 24'h000100, 8'd0, 1'b0, 5'd15, 24'h000100, 8'd0, 1'b0, 1'b1);
`else
      single("floor",    24'h000100, 8'd5, 1'b0, 5'd15, 24'h000000, 8'd0, 1'b1, 1'b1);
      single("floor_eq", 24'h008000, 8'd8, 1'b1, 5'd8,  24'h000000, 8'd0, 1'b1, 1'b1);
      single("floor_e0", 24'h000100, 8'd0, 1'b0, 5'd15, 24'h000000, 8'd0, 1'b1, 1'b1);
`endif
      // exp one above shift is still a normal result
      single("just_norm", 24'h008000, 8'd9, 1'b0, 5'd8, 24'h800000, 8'd1, 1'b0, 1'b0);

      // Backpressure: beat i = sig 0x400000|i, exp 50+i, shift 1
      //   -> sig 0x800000|(i<<1), exp 49+i
      @(negedge clk);
      out_ready = 1'b0;
      put(24'h400000, 8'd50, 1'b0, 5'd1);
      chk("bp.rdy0", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      put(24'h400001, 8'd51, 1'b1, 5'd1);
      chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
      chk("bp.ov1",  {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      put(24'h400002, 8'd52, 1'b0, 5'd1);
      chk("bp.full_rdy", {31'd0, in_ready}, 32'd0);
      chk_out("bp.b0a", 24'h800000, 8'd49, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp.stall_rdy1", {31'd0, in_ready}, 32'd0);
      chk_out("bp.b0b", 24'h800000, 8'd49, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp.stall_rdy2", {31'd0, in_ready}, 32'd0);
      chk_out("bp.b0c", 24'h800000, 8'd49, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      #1;
      chk("bp.comb_rdy", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk_out("bp.b1", 24'h800002, 8'd50, 1'b1, 1'b0, 1'b0);
      put(24'h400003, 8'd53, 1'b1, 5'd1);
      chk("bp.rdy3", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out("bp.b2", 24'h800004, 8'd51, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("bp.b3", 24'h800006, 8'd52, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp.empty", {31'd0, out_valid}, 32'd0);

      // Reset with two beats in flight
      out_ready = 1'b0;
      put(24'h00F000, 8'd100, 1'b0, 5'd8);
      @(negedge clk);
      put(24'h000001, 8'd200, 1'b0, 5'd23);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rm.pre_ov",  {31'd0, out_valid}, 32'd1);
      chk("rm.pre_rdy", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rm.ov",  {31'd0, out_valid}, 32'd0);
      chk("rm.rdy", {31'd0, in_ready}, 32'd1);
      chk("rm.sig", {8'd0, out_significand}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rm.ghost", {31'd0, out_valid}, 32'd0);
      end

      // Post-reset sanity
      single("post_rst", 24'h000F00, 8'd30, 1'b1, 5'd12, 24'hF00000, 8'd18, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
